// File: rtl/jtag_emu_pkg.sv
// Shared types and constants for the JTAG shift engine.
package jtag_emu_pkg;

  localparam int MAX_BITS_DEF = 32;
  localparam int DIV_W_DEF    = 8;
  localparam int LEN_W_DEF    = 6;

  // Shortest legal TCK half-period (in ps7_clk cycles, minus 1); keeps TCK
  // slow enough for the 2-flop TDO synchronizer to settle within a phase.
  localparam int MIN_DIV      = 2;
  localparam int SYNC_STAGES  = 2;

  // state       | meaning
  // ST_IDLE     | waiting for a command, pins parked (tck low)
  // ST_SHIFT_LO | TCK low phase of the current bit, TMS/TDI driven
  // ST_SHIFT_HI | TCK high phase, TDO sampled on the last cycle
  // ST_TRST     | TRSTn held low for len TCK periods, TCK parked low
  // ST_RESP     | response presented until the PS consumes it
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SHIFT_LO = 3'd1,
    ST_SHIFT_HI = 3'd2,
    ST_TRST     = 3'd3,
    ST_RESP     = 3'd4
  } state_e;

endpackage

// File: rtl/jtag_tdo_sync.sv
// Multi-flop synchronizer bringing PULPino's TDO into the ps7_clk domain.
module jtag_tdo_sync
  import jtag_emu_pkg::*;
#(
  parameter int STAGES = SYNC_STAGES
) (
  input  logic ps7_clk,
  input  logic ps7_rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge ps7_clk or negedge ps7_rst_n) begin
    if (!ps7_rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/jtag_emu_ctrl.sv
// JTAG shift engine: turns one PS command into up to MAX_BITS TAP cycles
// (or a TRSTn pulse) at a programmable TCK rate and returns captured TDO.
module jtag_emu_ctrl
  import jtag_emu_pkg::*;
#(
  parameter int MAX_BITS = MAX_BITS_DEF,
  parameter int DIV_W    = DIV_W_DEF,
  parameter int LEN_W    = LEN_W_DEF
) (
  input  logic                ps7_clk,
  input  logic                ps7_rst_n,
  input  logic [DIV_W-1:0]    cfg_div_i,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic                cmd_trst_i,
  input  logic [LEN_W-1:0]    cmd_len_i,
  input  logic [MAX_BITS-1:0] cmd_tms_i,
  input  logic [MAX_BITS-1:0] cmd_tdi_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [MAX_BITS-1:0] rsp_tdo_o,
  output logic                rsp_err_o,
  output logic                busy_o,
  output logic                tck_o,
  output logic                tms_o,
  output logic                tdi_o,
  output logic                trst_no,
  input  logic                tdo_i
);

  localparam int IDX_W = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;

  localparam logic [DIV_W:0] PH_ONE  = {{DIV_W{1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0] IDX_ONE = {{(IDX_W-1){1'b0}}, 1'b1};

  state_e              state_q;
  logic [DIV_W-1:0]    div_q;
  logic [DIV_W:0]      ph_q;
  logic [LEN_W-1:0]    len_q;
  logic [LEN_W-1:0]    bit_q;
  logic [MAX_BITS-1:0] tms_vec_q;
  logic [MAX_BITS-1:0] tdi_vec_q;
  logic [MAX_BITS-1:0] tdo_q;
  logic                tck_q;
  logic                tms_q;
  logic                tdi_q;
  logic                trst_n_q;
  logic                rsp_valid_q;
  logic                rsp_err_q;

  logic                sync_tdo;
  logic [DIV_W-1:0]    div_d;
  logic                len_bad;
  logic                last_bit;
  logic                ph_done;
  logic [IDX_W-1:0]    idx;
  logic [IDX_W-1:0]    idx_nxt;

  jtag_tdo_sync #(
    .STAGES (SYNC_STAGES)
  ) u_tdo_sync (
    .ps7_clk   (ps7_clk),
    .ps7_rst_n (ps7_rst_n),
    .d_i       (tdo_i),
    .q_o       (sync_tdo)
  );

  // Clamp the divider and classify the incoming command length.
  always_comb begin
    div_d   = (cfg_div_i < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : cfg_div_i;
    len_bad = (cmd_len_i == '0) || (cmd_len_i > LEN_W'(MAX_BITS));
  end

  // bit_q never exceeds MAX_BITS-1 while shifting, so the low bits suffice
  // as a vector index; idx_nxt is only used when another bit follows.
  assign idx      = bit_q[IDX_W-1:0];
  assign idx_nxt  = idx + IDX_ONE;
  assign last_bit = (bit_q == (len_q - LEN_ONE));
  assign ph_done  = (ph_q == '0);

  // Command sequencer with registered pin and response outputs.
  always_ff @(posedge ps7_clk or negedge ps7_rst_n) begin
    if (!ps7_rst_n) begin
      state_q     <= ST_IDLE;
      div_q       <= DIV_W'(MIN_DIV);
      ph_q        <= '0;
      len_q       <= '0;
      bit_q       <= '0;
      tms_vec_q   <= '0;
      tdi_vec_q   <= '0;
      tdo_q       <= '0;
      tck_q       <= 1'b0;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
      trst_n_q    <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (cmd_valid_i) begin
            div_q <= div_d;
            len_q <= cmd_len_i;
            bit_q <= '0;
            tdo_q <= '0;
            tck_q <= 1'b0;
            if (len_bad) begin
              state_q     <= ST_RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
            end else if (cmd_trst_i) begin
              state_q   <= ST_TRST;
              rsp_err_q <= 1'b0;
              trst_n_q  <= 1'b0;
              tms_q     <= 1'b1;
              // One full TCK period per count: 2*(div+1) cycles.
              ph_q      <= {div_d, 1'b1};
            end else begin
              state_q   <= ST_SHIFT_LO;
              rsp_err_q <= 1'b0;
              tms_vec_q <= cmd_tms_i;
              tdi_vec_q <= cmd_tdi_i;
              tms_q     <= cmd_tms_i[0];
              tdi_q     <= cmd_tdi_i[0];
              ph_q      <= {1'b0, div_d};
            end
          end
        end

        ST_SHIFT_LO: begin
          if (ph_done) begin
            state_q <= ST_SHIFT_HI;
            tck_q   <= 1'b1;
            ph_q    <= {1'b0, div_q};
          end else begin
            ph_q <= ph_q - PH_ONE;
          end
        end

        ST_SHIFT_HI: begin
          if (ph_done) begin
            tdo_q[idx] <= sync_tdo;
            tck_q      <= 1'b0;
            if (last_bit) begin
              state_q     <= ST_RESP;
              rsp_valid_q <= 1'b1;
            end else begin
              state_q <= ST_SHIFT_LO;
              bit_q   <= bit_q + LEN_ONE;
              tms_q   <= tms_vec_q[idx_nxt];
              tdi_q   <= tdi_vec_q[idx_nxt];
              ph_q    <= {1'b0, div_q};
            end
          end else begin
            ph_q <= ph_q - PH_ONE;
          end
        end

        ST_TRST: begin
          if (ph_done) begin
            if (last_bit) begin
              state_q     <= ST_RESP;
              trst_n_q    <= 1'b1;
              rsp_valid_q <= 1'b1;
            end else begin
              bit_q <= bit_q + LEN_ONE;
              ph_q  <= {div_q, 1'b1};
            end
          end else begin
            ph_q <= ph_q - PH_ONE;
          end
        end

        ST_RESP: begin
          if (rsp_ready_i) begin
            state_q     <= ST_IDLE;
            rsp_valid_q <= 1'b0;
          end
        end

        default: begin
          state_q     <= ST_IDLE;
          tck_q       <= 1'b0;
          trst_n_q    <= 1'b1;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready_o = (state_q == ST_IDLE);
  assign busy_o      = (state_q != ST_IDLE);
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_tdo_o   = tdo_q;
  assign rsp_err_o   = rsp_err_q;
  assign tck_o       = tck_q;
  assign tms_o       = tms_q;
  assign tdi_o       = tdi_q;
  assign trst_no     = trst_n_q;

endmodule

// File: tb/tb_jtag_emu_ctrl.sv
// Directed bench for the JTAG shift engine.
module tb_jtag_emu_ctrl;

  logic        ps7_clk;
  logic        ps7_rst_n;
  logic [7:0]  cfg_div;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_trst;
  logic [5:0]  cmd_len;
  logic [31:0] cmd_tms;
  logic [31:0] cmd_tdi;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_tdo;
  logic        rsp_err;
  logic        busy;
  logic        tck, tms, tdi, trst_n;
  logic        tdo_w;
  logic        loop_en;
  logic        tdo_val;

  int n_cmp;
  int n_bad;

  int lat, rises, hi_cyc, trst_lo, tms_low, tck_pat_bad;
  bit acc_ready;

  localparam int BUDGET = 2000;

  assign tdo_w = loop_en ? tdi : tdo_val;

  jtag_emu_ctrl dut (
    .ps7_clk     (ps7_clk),
    .ps7_rst_n   (ps7_rst_n),
    .cfg_div_i   (cfg_div),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_trst_i  (cmd_trst),
    .cmd_len_i   (cmd_len),
    .cmd_tms_i   (cmd_tms),
    .cmd_tdi_i   (cmd_tdi),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_tdo_o   (rsp_tdo),
    .rsp_err_o   (rsp_err),
    .busy_o      (busy),
    .tck_o       (tck),
    .tms_o       (tms),
    .tdi_o       (tdi),
    .trst_no     (trst_n),
    .tdo_i       (tdo_w)
  );

  initial ps7_clk = 1'b0;
  always #5 ps7_clk = ~ps7_clk;

  // Issue one command from a negedge, then watch the pins each cycle until
  // the response appears (lat = cycle number, 0 = budget expired) or the
  // abort cycle is reached. half = expected TCK phase length for pattern check.
  task automatic do_cmd(input bit trst_c, input int len, input int div,
                        input logic [31:0] tms_v, input logic [31:0] tdi_v,
                        input int half, input int abort_at);
    bit prev_tck;
    cmd_trst  = trst_c;
    cmd_len   = len[5:0];
    cfg_div   = div[7:0];
    cmd_tms   = tms_v;
    cmd_tdi   = tdi_v;
    cmd_valid = 1'b1;
    acc_ready = cmd_ready;
    @(posedge ps7_clk);
    #1;
    cmd_valid = 1'b0;
    cfg_div   = 8'hFF;
    lat = 0; rises = 0; hi_cyc = 0; trst_lo = 0; tms_low = 0; tck_pat_bad = 0;
    prev_tck = 1'b0;
    for (int c = 1; c <= BUDGET; c++) begin
      @(negedge ps7_clk);
      if (rsp_valid) begin
        lat = c;
        break;
      end
      if (tck && !prev_tck) rises++;
      prev_tck = tck;
      if (tck) hi_cyc++;
      if (!trst_n) trst_lo++;
      if (!tms) tms_low++;
      if (half > 0 && tck !== 1'(((c - 1) / half) % 2)) tck_pat_bad++;
      if (c == abort_at) break;
    end
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    @(posedge ps7_clk);
    #1;
    rsp_ready = 1'b0;
    @(negedge ps7_clk);
  endtask

  task automatic test_reset();
    ps7_rst_n = 1'b0;
    repeat (3) @(negedge ps7_clk);
    n_cmp++;
    if ({tck, tms, tdi, trst_n, rsp_valid, rsp_err, busy, cmd_ready} !== 8'b0101_0001) begin
      n_bad++;
      $display("FAIL reset_pins got=%b want=01010001",
               {tck, tms, tdi, trst_n, rsp_valid, rsp_err, busy, cmd_ready});
    end
    n_cmp++;
    if (rsp_tdo !== 32'h0) begin
      n_bad++; $display("FAIL reset_tdo got=%h want=0", rsp_tdo);
    end
    ps7_rst_n = 1'b1;
    @(negedge ps7_clk);
  endtask

  task automatic test_shift_basic();
    loop_en = 1'b0; tdo_val = 1'b0;
    do_cmd(1'b0, 5, 2, 32'h1F, 32'h0, 3, 0);
    n_cmp++;
    if (lat !== 31) begin n_bad++; $display("FAIL basic_latency got=%0d want=31", lat); end
    n_cmp++;
    if (rises !== 5) begin n_bad++; $display("FAIL basic_tck_pulses got=%0d want=5", rises); end
    n_cmp++;
    if (hi_cyc !== 15) begin n_bad++; $display("FAIL basic_tck_high got=%0d want=15", hi_cyc); end
    n_cmp++;
    if (tck_pat_bad !== 0) begin n_bad++; $display("FAIL basic_tck_shape bad_cycles=%0d want=0", tck_pat_bad); end
    n_cmp++;
    if (tms_low !== 0) begin n_bad++; $display("FAIL basic_tms_high low_cycles=%0d want=0", tms_low); end
    n_cmp++;
    if (rsp_err !== 1'b0 || rsp_tdo !== 32'h0) begin
      n_bad++; $display("FAIL basic_rsp err=%b tdo=%h want err=0 tdo=0", rsp_err, rsp_tdo);
    end
    n_cmp++;
    if (busy !== 1'b1 || cmd_ready !== 1'b0) begin
      n_bad++; $display("FAIL basic_busy busy=%b ready=%b want 1/0", busy, cmd_ready);
    end
    consume();
    n_cmp++;
    if ({rsp_valid, cmd_ready, busy, tck, tms} !== 5'b01001) begin
      n_bad++; $display("FAIL basic_idle got=%b want=01001", {rsp_valid, cmd_ready, busy, tck, tms});
    end
  endtask

  task automatic test_loopback();
    loop_en = 1'b1;
    do_cmd(1'b0, 32, 3, 32'h0, 32'hA5A51234, 4, 0);
    n_cmp++;
    if (lat !== 257) begin n_bad++; $display("FAIL loop_latency got=%0d want=257", lat); end
    n_cmp++;
    if (rsp_tdo !== 32'hA5A51234) begin n_bad++; $display("FAIL loop_tdo got=%h want=a5a51234", rsp_tdo); end
    n_cmp++;
    if (tck_pat_bad !== 0) begin n_bad++; $display("FAIL loop_tck_shape bad_cycles=%0d want=0", tck_pat_bad); end
    consume();
    n_cmp++;
    if (tck !== 1'b0 || tdi !== 1'b1 || tms !== 1'b0) begin
      n_bad++; $display("FAIL loop_idle_pins tck=%b tdi=%b tms=%b want 0/1/0", tck, tdi, tms);
    end
    loop_en = 1'b0;
  endtask

  task automatic test_div_clamp();
    tdo_val = 1'b1;
    do_cmd(1'b0, 8, 0, 32'h0, 32'h0, 3, 0);
    n_cmp++;
    if (lat !== 49) begin n_bad++; $display("FAIL clamp_latency got=%0d want=49", lat); end
    n_cmp++;
    if (rsp_tdo !== 32'h000000FF) begin n_bad++; $display("FAIL clamp_tdo got=%h want=000000ff", rsp_tdo); end
    n_cmp++;
    if (tck_pat_bad !== 0) begin n_bad++; $display("FAIL clamp_tck_shape bad_cycles=%0d want=0", tck_pat_bad); end
    consume();
    tdo_val = 1'b0;
  endtask

  task automatic test_trst();
    tdo_val = 1'b1;
    do_cmd(1'b1, 4, 2, 32'h0, 32'hFFFF_FFFF, 0, 0);
    n_cmp++;
    if (trst_lo !== 24) begin n_bad++; $display("FAIL trst_low_cycles got=%0d want=24", trst_lo); end
    n_cmp++;
    if (lat !== 25) begin n_bad++; $display("FAIL trst_latency got=%0d want=25", lat); end
    n_cmp++;
    if (rises !== 0 || tms_low !== 0) begin
      n_bad++; $display("FAIL trst_pins tck_rises=%0d tms_low=%0d want 0/0", rises, tms_low);
    end
    n_cmp++;
    if (rsp_tdo !== 32'h0 || rsp_err !== 1'b0 || trst_n !== 1'b1) begin
      n_bad++; $display("FAIL trst_rsp tdo=%h err=%b trstn=%b want 0/0/1", rsp_tdo, rsp_err, trst_n);
    end
    consume();
    tdo_val = 1'b0;
  endtask

  task automatic test_errors();
    int unstable;
    int ready_seen;
    do_cmd(1'b0, 0, 2, 32'h0, 32'h0, 0, 0);
    n_cmp++;
    if (lat !== 1 || rsp_err !== 1'b1) begin
      n_bad++; $display("FAIL err_len0 lat=%0d err=%b want 1/1", lat, rsp_err);
    end
    n_cmp++;
    if (rises !== 0 || tck !== 1'b0 || rsp_tdo !== 32'h0) begin
      n_bad++; $display("FAIL err_len0_pins rises=%0d tck=%b tdo=%h want 0/0/0", rises, tck, rsp_tdo);
    end
    unstable = 0; ready_seen = 0;
    cmd_valid = 1'b1; cmd_len = 6'd5; cmd_trst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge ps7_clk);
      if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_tdo !== 32'h0) unstable++;
      if (cmd_ready !== 1'b0) ready_seen++;
    end
    cmd_valid = 1'b0;
    n_cmp++;
    if (unstable !== 0) begin n_bad++; $display("FAIL err_hold_stable bad_cycles=%0d want=0", unstable); end
    n_cmp++;
    if (ready_seen !== 0) begin n_bad++; $display("FAIL err_hold_ready ready_cycles=%0d want=0", ready_seen); end
    consume();
    n_cmp++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      n_bad++; $display("FAIL err_handshake valid=%b ready=%b want 0/1", rsp_valid, cmd_ready);
    end
    do_cmd(1'b0, 33, 2, 32'h0, 32'h0, 0, 0);
    n_cmp++;
    if (lat !== 1 || rsp_err !== 1'b1 || rises !== 0) begin
      n_bad++; $display("FAIL err_len33 lat=%0d err=%b rises=%0d want 1/1/0", lat, rsp_err, rises);
    end
    consume();
  endtask

  task automatic test_back_to_back();
    tdo_val = 1'b1;
    do_cmd(1'b0, 3, 5, 32'h5, 32'h0, 6, 0);
    n_cmp++;
    if (lat !== 37 || rsp_tdo !== 32'h7 || tck_pat_bad !== 0) begin
      n_bad++; $display("FAIL b2b_first lat=%0d tdo=%h shape_bad=%0d want 37/7/0", lat, rsp_tdo, tck_pat_bad);
    end
    consume();
    n_cmp++;
    if (acc_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_first_ready got=%b want=1", acc_ready); end
    tdo_val = 1'b0; loop_en = 1'b1;
    do_cmd(1'b0, 1, 2, 32'h0, 32'h1, 3, 0);
    n_cmp++;
    if (lat !== 7 || rsp_tdo !== 32'h1 || rsp_err !== 1'b0) begin
      n_bad++; $display("FAIL b2b_second lat=%0d tdo=%h err=%b want 7/1/0", lat, rsp_tdo, rsp_err);
    end
    consume();
    loop_en = 1'b0;
  endtask

  task automatic test_reset_mid_shift();
    tdo_val = 1'b0;
    do_cmd(1'b0, 8, 2, 32'h0, 32'hFF, 3, 22);
    n_cmp++;
    if ({tck, tms, tdi, busy} !== 4'b1011) begin
      n_bad++; $display("FAIL mid_pre_reset got=%b want=1011", {tck, tms, tdi, busy});
    end
    ps7_rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({tck, tms, tdi, trst_n, rsp_valid, rsp_err, busy, cmd_ready} !== 8'b0101_0001 || rsp_tdo !== 32'h0) begin
      n_bad++; $display("FAIL mid_reset_pins got=%b tdo=%h want=01010001 tdo=0",
                        {tck, tms, tdi, trst_n, rsp_valid, rsp_err, busy, cmd_ready}, rsp_tdo);
    end
    @(negedge ps7_clk);
    ps7_rst_n = 1'b1;
    @(negedge ps7_clk);
    loop_en = 1'b1;
    do_cmd(1'b0, 2, 2, 32'h3, 32'h2, 3, 0);
    n_cmp++;
    if (lat !== 13 || rsp_tdo !== 32'h2 || rsp_err !== 1'b0 || acc_ready !== 1'b1) begin
      n_bad++; $display("FAIL mid_after_reset lat=%0d tdo=%h err=%b acc=%b want 13/2/0/1",
                        lat, rsp_tdo, rsp_err, acc_ready);
    end
    consume();
    loop_en = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    ps7_rst_n = 1'b0;
    cfg_div = 8'd2; cmd_valid = 1'b0; cmd_trst = 1'b0; cmd_len = '0;
    cmd_tms = '0; cmd_tdi = '0; rsp_ready = 1'b0;
    loop_en = 1'b0; tdo_val = 1'b0;
    @(negedge ps7_clk);
    test_reset();
    test_shift_basic();
    test_loopback();
    test_div_clamp();
    test_trst();
    test_errors();
    test_back_to_back();
    test_reset_mid_shift();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
